io_mem_wrapper: RTL
===================

IO_MEM_WRAPPER -- requirements
Module: io_mem_wrapper

Interface
REQ-001 Parameter MEM_WORDS, 1024: data-memory depth in 16-bit words, mapped at word addresses 0..MEM_WORDS-1.
REQ-002 Parameter OUT_DEPTH, 4: output FIFO depth in entries, power of two, at least 2.
REQ-003 Parameter IN_ADDR, 16'hFFFE: input-port word address.
REQ-004 Parameter OUT_ADDR, 16'hFFFF: output-port word address.
REQ-005 Parameter STATUS_ADDR, 16'hFFFD: status-register word address.
REQ-006 CLK  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
REQ-008 addr  in  16  word address from the datapath IorD mux.
REQ-009 wdata  in  16  store data (datapath register-file output).
REQ-010 memw  in  1  store strobe.
REQ-011 rd_en  in  1  load strobe; needed only for side-effecting reads.
REQ-012 rdata  out  16  registered read data feeding the datapath MDR.
REQ-013 in_data  in  16  external input word.
REQ-014 in_valid  in  1  in_data valid.
REQ-015 in_ready  out  1  input holding register empty.
REQ-016 out_data  out  16  output FIFO head.
REQ-017 out_valid  out  1  FIFO non-empty.
REQ-018 out_ready  in  1  consumer accepts out_data.
REQ-019 out_full  out  1  FIFO holds OUT_DEPTH entries.
REQ-020 out_overflow  out  1  sticky flag: a store to OUT_ADDR was dropped.

Function
REQ-021 rdata updates every cycle from the current addr, one-cycle latency.
REQ-022 Memory store: memw with addr < MEM_WORDS writes wdata at that edge. A same-cycle read of that address returns the old value (read-before-write).
REQ-023 Unmapped addresses (not below MEM_WORDS and not IN_ADDR, OUT_ADDR or STATUS_ADDR) read 0; stores to them are ignored.
REQ-024 Input path: in_ready = !in_full. The edge where in_valid && in_ready are both high captures in_data into in_hold and sets in_full.
REQ-025 A read at IN_ADDR returns in_hold if in_full, else 0. A read with rd_en=1 and in_full=1 clears in_full at that edge, so in_ready rises next cycle.
REQ-026 A read at IN_ADDR with rd_en=0 has no side effect.
REQ-027 Output FIFO push: memw with addr==OUT_ADDR pushes wdata. If the FIFO is full with no simultaneous pop, the word is dropped and out_overflow is set.
REQ-028 FIFO pop: the edge where out_valid && out_ready are both high removes the head.
REQ-029 Simultaneous push and pop are both accepted in every state, including full (count unchanged). Push into empty with pop is impossible because out_valid=0.
REQ-030 Occupancy count runs 0..OUT_DEPTH. Read and write pointers wrap modulo OUT_DEPTH.
REQ-031 out_valid = count!=0; out_full = count==OUT_DEPTH; out_data = the entry at the read pointer; all three are registered-state derived.
REQ-032 A read at OUT_ADDR returns 0.

Reset
REQ-033 Under reset: rdata=0, in_full=0 (in_ready=1), in_hold=0, FIFO pointers and count=0 (out_valid=0, out_full=0, out_data=0), out_overflow=0.
REQ-034 Memory array contents are not reset.
REQ-035 Reset asserted mid-transfer discards any captured input and all FIFO contents; no partial push or pop completes.

Configuration
REQ-036 Macro IO_STATUS_EN defined:
- a read at STATUS_ADDR returns {13'b0, out_overflow, out_full, in_full};
- a store at STATUS_ADDR clears out_overflow;
- out_overflow behaves per REQ-027.
REQ-037 Macro IO_STATUS_EN undefined: STATUS_ADDR is unmapped per REQ-023, and out_overflow is tied 0.

Verification
REQ-038 Store 16'h1234 at address 5, then read address 5 -> rdata=16'h1234 one cycle after addr is presented.
REQ-039 in_data=16'h00AB, in_valid=1 for one cycle -> in_ready=0. Read IN_ADDR with rd_en=1 -> rdata=16'h00AB, in_ready=1 next cycle; a second read -> 0.
REQ-040 out_ready=0, store 1,2,3,4,5 to OUT_ADDR -> out_full=1, out_overflow=1. With out_ready=1 the pops yield 1,2,3,4, then out_valid=0.
REQ-041 With the FIFO full, push 9 while popping -> push accepted, count stays 4, out_overflow unchanged, 9 emerges last.
REQ-042 Pulse reset low with 2 FIFO entries and in_full=1 -> out_valid=0, in_ready=1, rdata=0 immediately.
REQ-043 IO_STATUS_EN defined: after overflow, read STATUS_ADDR -> 16'h0006 (full FIFO, empty input). Store to STATUS_ADDR -> out_overflow=0.

Source files
------------

// File: rtl/io_mem_wrapper.sv
// Memory-mapped IO wrapper: data memory, input holding register, output FIFO.
// Optional status register at STATUS_ADDR enabled by defining IO_STATUS_EN.
module io_mem_wrapper #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          OUT_DEPTH   = 4,
  parameter logic [15:0] IN_ADDR     = 16'hFFFE,
  parameter logic [15:0] OUT_ADDR    = 16'hFFFF,
  parameter logic [15:0] STATUS_ADDR = 16'hFFFD
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        memw,
  input  logic        rd_en,
  output logic [15:0] rdata,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_full,
  output logic        out_overflow
);

  localparam int          AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          PW      = $clog2(OUT_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [16:0] MEM_LIM = 17'(MEM_WORDS);

  logic [15:0]   mem [MEM_WORDS];
  logic [AW-1:0] mem_idx;
  logic          mem_hit;
  logic [15:0]   rd_next;

  logic          in_full;
  logic [15:0]   in_hold;
  logic          in_cap;
  logic          in_clr;

  logic [15:0]   fifo [OUT_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic [15:0]   status_word;

  assign mem_hit = ({1'b0, addr} < MEM_LIM);
  assign mem_idx = addr[AW-1:0];

  // Memory array has no reset; contents survive a reset pulse.
  always_ff @(posedge CLK) begin
    if (memw && mem_hit)
      mem[mem_idx] <= wdata;
  end

  assign in_ready  = !in_full;
  assign out_valid = (count != '0);
  assign out_full  = (count == CW'(OUT_DEPTH));
  assign out_data  = fifo[rd_ptr];

`ifdef IO_STATUS_EN
  assign status_word = {13'b0, out_overflow, out_full, in_full};
`else
  assign status_word = 16'h0000;
`endif

  always_comb begin
    rd_next = 16'h0000;
    if (mem_hit)
      rd_next = mem[mem_idx];
    else if (addr == IN_ADDR)
      rd_next = in_full ? in_hold : 16'h0000;
    else if (addr == STATUS_ADDR)
      rd_next = status_word;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      rdata <= 16'h0000;
    else
      rdata <= rd_next;
  end

  // Capture and clear are exclusive: capture needs an empty holding register.
  assign in_cap = in_valid && !in_full;
  assign in_clr = rd_en && (addr == IN_ADDR) && in_full;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      in_full <= 1'b0;
      in_hold <= 16'h0000;
    end else if (in_cap) begin
      in_full <= 1'b1;
      in_hold <= in_data;
    end else if (in_clr) begin
      in_full <= 1'b0;
    end
  end

  assign push_req = memw && (addr == OUT_ADDR);
  assign pop      = out_valid && out_ready;
  assign push_ok  = push_req && (!out_full || pop);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++)
        fifo[i] <= 16'h0000;
    end else begin
      if (push_ok) begin
        fifo[wr_ptr] <= wdata;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (pop && !push_ok)
        count <= count - 1'b1;
    end
  end

`ifdef IO_STATUS_EN
  logic ovf_q;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      ovf_q <= 1'b0;
    else if (memw && (addr == STATUS_ADDR))
      ovf_q <= 1'b0;
    else if (push_req && !push_ok)
      ovf_q <= 1'b1;
  end

  assign out_overflow = ovf_q;
`else
  assign out_overflow = 1'b0;
`endif

endmodule
